guess_display: RTL and testbench

Output-side driver for the number-guessing game, the display counterpart to the DIP keypad encoder. It accepts two 8-bit binary values (typically the LL/HL limits or guess/limit pairs) on a load strobe and converts them to BCD with a sequential double-dabble engine. It then drives a 4-digit, time-multiplexed, active-low 7-segment display. It also overrides the digits with a "donE" message on game completion and blinks the display while the guess is out of range.

---
 rtl/guess_display_if.sv | 9 +
 rtl/guess_display.sv | 99 +++++++++
 tb/tb_guess_display.sv | 126 ++++++++++++
 3 files changed

// File: rtl/guess_display_if.sv
// guess_display_if: load/operand/status inputs and multiplexed 7-segment outputs of guess_display
interface guess_display_if;
   logic       load, done, outrange, busy, dp;
   logic [7:0] a, b;
   logic [6:0] seg;
   logic [3:0] an;
   modport master (output load, a, b, done, outrange, input busy, seg, dp, an);
   modport slave (input load, a, b, done, outrange, output busy, seg, dp, an);
endinterface

// File: rtl/guess_display.sv
// guess_display: double-dabble BCD conversion of two clamped operands driving a blinking
// 4-digit time-multiplexed active-low 7-segment display with a "donE" override
module guess_display #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input logic            clk,
   input logic            rst,
   guess_display_if.slave bus
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [6:0] DIG [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t        st;
   logic [15:0]   sa, sb;
   logic [2:0]    it;
   logic [3:0]    d3, d2, d1, d0, cur;
   logic [DW-1:0] div;
   logic [FW-1:0] frame;
   logic [1:0]    idx;
   logic          phase, busy, dark;
   logic [6:0]    num, msg;

   function automatic logic [7:0] clamp(input logic [7:0] v);
      return v > 8'd99 ? 8'd99 : v;
   endfunction

   // {bcd tens, bcd ones, binary}: adjust nibbles >=5 then shift one bit in
   function automatic logic [15:0] dabble(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      if (r[15:12] >= 4'd5) r[15:12] = r[15:12] + 4'd3;
      if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
      return r << 1;
   endfunction

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st   <= IDLE;
         busy <= 1'b0;
         sa   <= '0;
         sb   <= '0;
         it   <= '0;
         {d3, d2, d1, d0} <= '0;
      end else case (st)
         IDLE: if (bus.load) begin
            sa   <= {8'd0, clamp(bus.a)};
            sb   <= {8'd0, clamp(bus.b)};
            it   <= '0;
            busy <= 1'b1;
            st   <= SHIFT;
         end
         SHIFT: begin
            sa <= dabble(sa);
            sb <= dabble(sb);
            it <= it + 3'd1;
            if (it == 3'd7) st <= COMMIT;
         end
         default: begin
            {d3, d2} <= sa[15:8];
            {d1, d0} <= sb[15:8];
            busy     <= 1'b0;
            st       <= IDLE;
         end
      endcase

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div   <= '0;
         idx   <= '0;
         frame <= '0;
         phase <= 1'b1;
      end else begin
         div <= div == DW'(SCAN_DIV - 1) ? '0 : div + 1'b1;
         if (div == DW'(SCAN_DIV - 1)) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               frame <= frame == FW'(BLINK_FRAMES - 1) ? '0 : frame + 1'b1;
               if (frame == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
            end
         end
      end

   always_comb begin
      cur      = idx == 2'd3 ? d3 : idx == 2'd2 ? d2 : idx == 2'd1 ? d1 : d0;
      num      = idx[0] && cur == 4'd0 ? 7'b1111111 : DIG[cur];
      msg      = idx == 2'd3 ? 7'b1000010 : idx == 2'd2 ? 7'b1100010 :
                 idx == 2'd1 ? 7'b1101010 : 7'b0110000;
      dark     = bus.outrange && !phase;
      bus.seg  = bus.done ? msg : dark ? 7'b1111111 : num;
      bus.dp   = bus.done || dark || idx != 2'd2;
      bus.an   = ~(4'b0001 << idx);
      bus.busy = busy;
   end
endmodule

// File: tb/tb_guess_display.sv
// tb_guess_display: directed and random stimulus against a cycle-count based model of
// conversion latency, scan position, blink phase and display priority
module tb_guess_display;
   localparam int SD = 3, BF = 2;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   guess_display_if bus ();
   guess_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (.clk(clk), .rst(rst), .bus(bus));

   localparam logic [6:0] DIG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   localparam logic [6:0] MSG [4] = '{7'b0110000, 7'b1101010, 7'b1100010, 7'b1000010};

   int n_chk = 0, n_fail = 0;
   int t = 0, busy_left = 0, va = 0, vb = 0, pa = 0, pb = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      int idx, v, dig;
      bit on;
      logic [6:0] es;
      logic edp;
      logic [3:0] ean;
      idx = (t / SD) % 4;
      on  = ((t / (4 * SD * BF)) % 2) == 0;
      v   = idx >= 2 ? va : vb;
      dig = idx % 2 == 1 ? v / 10 : v % 10;
      ean = ~(4'b0001 << idx);
      if (bus.done) begin
         es = MSG[idx]; edp = 1'b1;
      end else if (bus.outrange && !on) begin
         es = 7'b1111111; edp = 1'b1;
      end else begin
         es = (idx % 2 == 1 && dig == 0) ? 7'b1111111 : DIG[dig];
         edp = idx != 2;
      end
      chk({tag, ".an"}, bus.an, ean);
      chk({tag, ".seg"}, bus.seg, es);
      chk({tag, ".dp"}, bus.dp, edp);
      chk({tag, ".busy"}, bus.busy, busy_left > 0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      t++;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin va = pa; vb = pb; end
      end else if (bus.load) begin
         busy_left = 9;
         pa = bus.a > 99 ? 99 : int'(bus.a);
         pb = bus.b > 99 ? 99 : int'(bus.b);
      end
      #1;
      check(tag);
   endtask

   task automatic do_load(input int a, input int b);
      bus.a = 8'(a); bus.b = 8'(b); bus.load = 1'b1;
      step("load");
      bus.load = 1'b0;
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      #1;
      t = 0; busy_left = 0; va = 0; vb = 0;
      check("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0; bus.a = '0; bus.b = '0; bus.done = 1'b0; bus.outrange = 1'b0;
      do_reset();
      run("scan", 14);
      do_reset();
      run("scan2", 13);
      do_load(37, 5);
      run("conv37", 8 + 4 * SD);
      do_load(150, 100);
      run("clamp", 9 + 4 * SD);
      do_load(0, 99);
      run("zero", 9 + 4 * SD);
      do_load(11, 22);
      do_load(33, 44);
      run("busyign", 7);
      do_load(55, 66);
      do_load(77, 88);
      run("accept", 9 + 4 * SD);
      chk("accepted_a", 32'(va), 77);
      chk("accepted_b", 32'(vb), 88);
      bus.outrange = 1'b1;
      run("blink", 60);
      bus.done = 1'b1;
      run("done", 30);
      bus.done = 1'b0;
      bus.outrange = 1'b0;
      run("idle", 5);
      do_load(42, 0);
      run("shift", 4);
      do_reset();
      run("abort", 20);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) bus.done = ~bus.done;
         if ($urandom_range(0, 7) == 0) bus.outrange = ~bus.outrange;
         if ($urandom_range(0, 5) == 0) do_load($urandom_range(0, 255), $urandom_range(0, 255));
         else step("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
